hazard_ctrl: RTL and testbench



---
 rtl/cpu_param.sv | 36 +++
 rtl/md_busy_counter.sv | 27 ++
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_param.sv
// rtl/cpu_param.sv - shared pipeline constants and shadow-entry type for the hazard controller
package cpu_param;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_E   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_W   = 2'd3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       md;
        logic       div;
    } shadow_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] sel;
    } op_res_t;

    // One pipeline step closer to the result: tnew counts down and stays at 0.
    function automatic shadow_t shadow_age(input shadow_t s);
        shadow_t r;
        r = s;
        r.tnew = (s.tnew == 2'd0) ? 2'd0 : s.tnew - 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// rtl/md_busy_counter.sv - mult/div busy counter: loads on start, counts down to zero
module md_busy_counter #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CW          = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          div,
    output logic          busy,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush and forwarding control for the five-stage core
// Optional mult/div sequencing is built only when HAZARD_MD_EN is defined.
module hazard_ctrl
    import cpu_param::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [1:0] id_tuse_rs,
    input  logic [1:0] id_tuse_rt,
    input  logic [4:0] id_dst,
    input  logic [1:0] id_tnew,
    input  logic       id_md_start,
    input  logic       id_md_div,
    input  logic       id_md_use,
    output logic       stall,
    output logic       pc_en,
    output logic       fd_en,
    output logic       de_clr,
    output logic [1:0] fwd_id_rs,
    output logic [1:0] fwd_id_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       md_start,
    output logic       md_busy
);

    shadow_t e_q, m_q, w_q;
    shadow_t e_in;
    op_res_t rs_res, rt_res;
    logic    md_stall;

    // Only the nearest writer of an operand decides both stall and forward source.
    function automatic op_res_t id_check(input logic [4:0] a, input logic [1:0] tuse,
                                         input shadow_t e, input shadow_t m, input shadow_t w);
        op_res_t r;
        r = '0;
        if (tuse != TUSE_NONE && a != 5'd0) begin
            if (e.dst == a) begin
                r.stall = (e.tnew > tuse);
                r.sel   = (e.tnew == 2'd0) ? FWD_E : FWD_GRF;
            end else if (m.dst == a) begin
                r.stall = (m.tnew > tuse);
                r.sel   = (m.tnew == 2'd0) ? FWD_M : FWD_GRF;
            end else if (w.dst == a) begin
                r.stall = (w.tnew > tuse);
                r.sel   = (w.tnew == 2'd0) ? FWD_W : FWD_GRF;
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] e_check(input logic [4:0] a, input shadow_t m, input shadow_t w);
        logic [1:0] sel;
        sel = FWD_GRF;
        if (a != 5'd0) begin
            if (m.dst == a) begin
                sel = (m.tnew == 2'd0) ? FWD_M : FWD_GRF;
            end else if (w.dst == a) begin
                sel = (w.tnew == 2'd0) ? FWD_W : FWD_GRF;
            end
        end
        return sel;
    endfunction

    always_comb begin
        rs_res = id_check(id_rs, id_tuse_rs, e_q, m_q, w_q);
        rt_res = id_check(id_rt, id_tuse_rt, e_q, m_q, w_q);
    end

    assign stall     = rs_res.stall | rt_res.stall | md_stall;
    assign pc_en     = ~stall;
    assign fd_en     = ~stall;
    assign de_clr    = stall;
    assign fwd_id_rs = rs_res.sel;
    assign fwd_id_rt = rt_res.sel;
    assign fwd_e_rs  = e_check(e_q.rs, m_q, w_q);
    assign fwd_e_rt  = e_check(e_q.rt, m_q, w_q);

    always_comb begin
        e_in = '0;
        if (!stall) begin
            e_in.rs   = id_rs;
            e_in.rt   = id_rt;
            e_in.dst  = id_dst;
            e_in.tnew = id_tnew;
`ifdef HAZARD_MD_EN
            e_in.md   = id_md_start;
            e_in.div  = id_md_start & id_md_div;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_in;
            m_q <= shadow_age(e_q);
            w_q <= shadow_age(m_q);
        end
    end

`ifdef HAZARD_MD_EN
    localparam int MD_MAX = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int MD_CW  = $clog2(MD_MAX + 1);

    logic [MD_CW-1:0] md_count;
    logic             unused_md;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CW          (MD_CW)
    ) u_md_busy_counter (
        .clk   (clk),
        .reset (reset),
        .start (e_q.md),
        .div   (e_q.div),
        .busy  (md_busy),
        .count (md_count)
    );

    assign md_start  = e_q.md;
    // A HI/LO consumer also waits out the start cycle, before the counter has loaded.
    assign md_stall  = id_md_use & (md_busy | md_start);
    assign unused_md = ^md_count;
`else
    logic unused_md;

    assign md_start  = 1'b0;
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
    assign unused_md = ^{id_md_start, id_md_div, id_md_use, e_q.md, e_q.div};
`endif

    logic unused_shadow;
    assign unused_shadow = ^{m_q.rs, m_q.rt, m_q.md, m_q.div, w_q.rs, w_q.rt, w_q.md, w_q.div};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

`ifdef HAZARD_MD_EN
    localparam int MD_EN = 1;
`else
    localparam int MD_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, id_dst;
    logic [1:0] id_tuse_rs, id_tuse_rt, id_tnew;
    logic       id_md_start, id_md_div, id_md_use;
    logic       stall, pc_en, fd_en, de_clr, md_start, md_busy;
    logic [1:0] fwd_id_rs, fwd_id_rt, fwd_e_rs, fwd_e_rt;

    int n_chk = 0;
    int n_bad = 0;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_tuse_rs  (id_tuse_rs),
        .id_tuse_rt  (id_tuse_rt),
        .id_dst      (id_dst),
        .id_tnew     (id_tnew),
        .id_md_start (id_md_start),
        .id_md_div   (id_md_div),
        .id_md_use   (id_md_use),
        .stall       (stall),
        .pc_en       (pc_en),
        .fd_en       (fd_en),
        .de_clr      (de_clr),
        .fwd_id_rs   (fwd_id_rs),
        .fwd_id_rt   (fwd_id_rt),
        .fwd_e_rs    (fwd_e_rs),
        .fwd_e_rt    (fwd_e_rt),
        .md_start    (md_start),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int observed, input int expected);
        n_chk++;
        assert (observed === expected) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int rs, input int rt, input int tuse_rs, input int tuse_rt,
                          input int dst, input int tnew, input int mds, input int mdd, input int mdu);
        id_rs       = 5'(rs);
        id_rt       = 5'(rt);
        id_tuse_rs  = 2'(tuse_rs);
        id_tuse_rt  = 2'(tuse_rt);
        id_dst      = 5'(dst);
        id_tnew     = 2'(tnew);
        id_md_start = mds[0];
        id_md_div   = mdd[0];
        id_md_use   = mdu[0];
        #1;
    endtask

    task automatic set_nop();
        set_id(0, 0, 3, 3, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_pc_en"}, pc_en, 1);
        chk({tag, "_fd_en"}, fd_en, 1);
        chk({tag, "_de_clr"}, de_clr, 0);
        chk({tag, "_fwd_id_rs"}, fwd_id_rs, 0);
        chk({tag, "_fwd_id_rt"}, fwd_id_rt, 0);
        chk({tag, "_fwd_e_rs"}, fwd_e_rs, 0);
        chk({tag, "_fwd_e_rt"}, fwd_e_rt, 0);
        chk({tag, "_md_start"}, md_start, 0);
        chk({tag, "_md_busy"}, md_busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        set_nop();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk_idle("reset");

        // lw $1 then addu $2,$1,$3
        set_id(2, 1, 1, 3, 1, 2, 0, 0, 0);
        chk("lw_issue_stall", stall, 0);
        tick();
        set_id(1, 3, 1, 1, 2, 1, 0, 0, 0);
        chk("lwuse_stall", stall, 1);
        chk("lwuse_de_clr", de_clr, 1);
        chk("lwuse_pc_en", pc_en, 0);
        chk("lwuse_fd_en", fd_en, 0);
        tick();
        chk("lwuse_release", stall, 0);
        chk("lwuse_fwd_id_rs", fwd_id_rs, 0);
        tick();
        set_nop();
        chk("lwuse_fwd_e_rs", fwd_e_rs, 3);
        chk("lwuse_fwd_e_rt", fwd_e_rt, 0);

        // addiu $5 then beq $5,$0
        set_id(6, 0, 1, 3, 5, 1, 0, 0, 0);
        chk("addiu_stall", stall, 0);
        tick();
        set_id(5, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("beq_stall", stall, 1);
        chk("beq_fwd_id_rt", fwd_id_rt, 0);
        tick();
        chk("beq_release", stall, 0);
        chk("beq_fwd_id_rs", fwd_id_rs, 2);
        tick();

        // addu $4, addu $4,$4, jr $4: nearest writer wins
        set_id(7, 8, 1, 1, 4, 1, 0, 0, 0);
        chk("a4a_stall", stall, 0);
        tick();
        set_id(4, 9, 1, 1, 4, 1, 0, 0, 0);
        chk("a4b_stall", stall, 0);
        chk("a4b_fwd_id_rs", fwd_id_rs, 0);
        tick();
        set_id(4, 0, 0, 3, 0, 0, 0, 0, 0);
        chk("jr_stall", stall, 1);
        chk("jr_fwd_id_rs_wait", fwd_id_rs, 0);
        chk("a4b_fwd_e_rs", fwd_e_rs, 2);
        tick();
        chk("jr_release", stall, 0);
        chk("jr_fwd_id_rs", fwd_id_rs, 2);
        tick();

        // $0 never forwards or stalls
        set_id(1, 2, 1, 1, 0, 1, 0, 0, 0);
        chk("dst0_stall", stall, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_stall", stall, 0);
        chk("r0_fwd_id_rs", fwd_id_rs, 0);
        chk("r0_fwd_id_rt", fwd_id_rt, 0);
        chk("r0_fwd_e_rs", fwd_e_rs, 0);
        chk("r0_fwd_e_rt", fwd_e_rt, 0);
        tick();

        // lw $10 then addu $11,$10,$10: both operands hazard at once
        set_id(0, 0, 1, 3, 10, 2, 0, 0, 0);
        chk("lw10_stall", stall, 0);
        tick();
        set_id(10, 10, 1, 1, 11, 1, 0, 0, 0);
        chk("dual_stall", stall, 1);
        chk("dual_fwd_id_rs", fwd_id_rs, 0);
        chk("dual_fwd_id_rt", fwd_id_rt, 0);
        tick();
        chk("dual_release", stall, 0);
        chk("dual_rel_fwd_id_rs", fwd_id_rs, 0);
        chk("dual_rel_fwd_id_rt", fwd_id_rt, 0);
        tick();
        set_nop();
        chk("dual_fwd_e_rs", fwd_e_rs, 3);
        chk("dual_fwd_e_rt", fwd_e_rt, 3);

        // div then mflo
        set_id(12, 13, 1, 1, 0, 0, 1, 1, 1);
        chk("div_issue_stall", stall, 0);
        chk("div_issue_md_start", md_start, 0);
        chk("div_issue_md_busy", md_busy, 0);
        tick();
        set_id(0, 0, 3, 3, 14, 1, 0, 0, 1);
        chk("div_e_md_start", md_start, MD_EN);
        chk("div_e_stall", stall, MD_EN);
        chk("div_e_md_busy", md_busy, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("div_busy_%0d", k), md_busy, MD_EN);
            chk($sformatf("div_hold_%0d", k), stall, MD_EN);
            chk($sformatf("div_start_%0d", k), md_start, 0);
        end
        tick();
        chk("div_done_busy", md_busy, 0);
        chk("div_done_stall", stall, 0);
        tick();

        // reset while stalled with count=7
        set_id(12, 13, 1, 1, 0, 0, 1, 1, 1);
        chk("div2_issue_stall", stall, 0);
        tick();
        set_id(0, 0, 3, 3, 14, 1, 0, 0, 1);
        for (int k = 0; k < 4; k++) tick();
        chk("rst_mid_stall_before", stall, MD_EN);
        chk("rst_mid_busy_before", md_busy, MD_EN);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_de_clr", de_clr, 0);
        chk("rst_mid_busy", md_busy, 0);
        chk("rst_mid_md_start", md_start, 0);
        chk("rst_mid_fwd_id_rs", fwd_id_rs, 0);
        chk("rst_mid_fwd_e_rs", fwd_e_rs, 0);
        tick();
        chk("rst_after_busy", md_busy, 0);
        chk("rst_after_stall", stall, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
